// File: rtl/sram_bus_phy_pkg.sv
// sram_bus_phy_pkg
// Shared definitions for the SRAM bus responder: FSM state encoding, command
// bit positions, the default PHY identifier, the wait-state register width
// and a helper that maps a command onto the active-low byte-lane strobes.
package sram_bus_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_CTRL   = 3'd4
    } state_t;

    localparam int CMD_CTRL = 2;
    localparam int CMD_RD   = 1;
    localparam int CMD_LANE = 0;

    localparam logic [7:0] PHY_ID_DEFAULT = 8'hC2;

    localparam int WAIT_W = 4;

    // Returns {ub_n, lb_n}. Reads enable both lanes; writes enable only the
    // lane picked by the command (1 = upper byte).
    function automatic logic [1:0] lanes_n(input logic rd, input logic upper);
        if (rd) begin
            return 2'b00;
        end
        return upper ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/sram_bus_phy.sv
// sram_bus_phy
// Responder end of the internal memory request bus. Takes single-word
// go/cmd requests and runs them against the external 16-bit asynchronous
// SRAM with a programmable number of wait states, or against the small
// internal status/config register when the control bit is set.
// Every pin output comes straight from a flop.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   addr_i[23:0]   word address, bits above ADDR_W ignored
//   data_i[15:0]   write data (same byte on both lanes)
//   go_i           one-cycle request strobe
//   cmd_i[2:0]     [2] control op, [1] 1=read/0=write, [0] write lane (1=upper)
//   busy_o         request in progress
//   valid_o        one-cycle completion pulse
//   data_o[15:0]   read data, held until the next read completes
//   sram_a_o       SRAM word address
//   sram_dq_i/o    SRAM data in / out, sram_dq_oe_o is the pad output enable
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o
//                  active-low SRAM strobes
//
// Build option
//   SRAM_BUS_PHY_DROPCNT_EN : adds an 8-bit saturating count of go_i pulses
//   ignored while busy. Control read then returns it in the upper byte in
//   place of PHY_ID, and a control write with data_i[15]=1 clears it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for go_i, all strobes released
// SETUP  | address, ce_n and lanes driven (write data driven too)
// ACCESS | oe_n or we_n low for wait_r+1 cycles, read data sampled last
// DONE   | oe_n/we_n released, ce_n/address/dq held, valid_o pulse
// CTRL   | internal register access, no SRAM activity
module sram_bus_phy
    import sram_bus_phy_pkg::*;
#(
    parameter int                ADDR_W      = 20,
    parameter logic [WAIT_W-1:0] WAIT_STATES = 4'd2,
    parameter logic [7:0]        PHY_ID      = PHY_ID_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [23:0]       addr_i,
    input  logic [15:0]       data_i,
    input  logic              go_i,
    input  logic [2:0]        cmd_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [15:0]       data_o,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    state_t            state;
    logic              rd_r;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] ctrl_wd_r;
    logic [7:0]        ctrl_hi;

`ifdef SRAM_BUS_PHY_DROPCNT_EN
    logic       ctrl_clr_r;
    logic [7:0] dropcnt_r;

    assign ctrl_hi = dropcnt_r;
`else
    assign ctrl_hi = PHY_ID;
`endif

    // Upper request-address bits are deliberately dropped.
    generate
        if (ADDR_W < 24) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_i[23:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= ST_IDLE;
            rd_r         <= 1'b0;
            wait_r       <= WAIT_STATES;
            cnt_r        <= '0;
            ctrl_wd_r    <= '0;
            busy_o       <= 1'b0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            sram_a_o     <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_ub_n_o  <= 1'b1;
            sram_lb_n_o  <= 1'b1;
`ifdef SRAM_BUS_PHY_DROPCNT_EN
            ctrl_clr_r   <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go_i) begin
                        busy_o    <= 1'b1;
                        rd_r      <= cmd_i[CMD_RD];
                        ctrl_wd_r <= data_i[WAIT_W-1:0];
`ifdef SRAM_BUS_PHY_DROPCNT_EN
                        ctrl_clr_r <= data_i[15];
`endif
                        if (cmd_i[CMD_CTRL]) begin
                            state <= ST_CTRL;
                        end else begin
                            // Pin registers are loaded here so SETUP already
                            // presents address, chip enable and lanes.
                            state       <= ST_SETUP;
                            sram_a_o    <= addr_i[ADDR_W-1:0];
                            sram_ce_n_o <= 1'b0;
                            {sram_ub_n_o, sram_lb_n_o} <=
                                lanes_n(cmd_i[CMD_RD], cmd_i[CMD_LANE]);
                            if (!cmd_i[CMD_RD]) begin
                                sram_dq_o    <= data_i;
                                sram_dq_oe_o <= 1'b1;
                            end
                        end
                    end
                end

                ST_SETUP: begin
                    state <= ST_ACCESS;
                    cnt_r <= wait_r;
                    if (rd_r) begin
                        sram_oe_n_o <= 1'b0;
                    end else begin
                        sram_we_n_o <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (cnt_r == '0) begin
                        state       <= ST_DONE;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        busy_o      <= 1'b0;
                        valid_o     <= 1'b1;
                        if (rd_r) begin
                            data_o <= sram_dq_i;
                        end
                    end else begin
                        cnt_r <= cnt_r - WAIT_W'(1);
                    end
                end

                ST_DONE: begin
                    // ce_n, address, lanes and dq were held through DONE to
                    // give the write its hold time; release them now.
                    state        <= ST_IDLE;
                    sram_ce_n_o  <= 1'b1;
                    sram_ub_n_o  <= 1'b1;
                    sram_lb_n_o  <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                end

                ST_CTRL: begin
                    state   <= ST_DONE;
                    busy_o  <= 1'b0;
                    valid_o <= 1'b1;
                    if (rd_r) begin
                        data_o <= {ctrl_hi, 4'h0, wait_r};
                    end else begin
                        wait_r <= ctrl_wd_r;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_BUS_PHY_DROPCNT_EN
    // Clear beats a simultaneous drop so a clearing write always leaves zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dropcnt_r <= '0;
        end else if (state == ST_CTRL && !rd_r && ctrl_clr_r) begin
            dropcnt_r <= '0;
        end else if (go_i && busy_o && dropcnt_r != 8'hFF) begin
            dropcnt_r <= dropcnt_r + 8'd1;
        end
    end
`endif

endmodule
